rv523_bus_responder: RTL
========================

RV523_BUS_RESPONDER -- requirements
Module: rv523_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait states per access; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-011 SHALL have port rsp_valid  output  1  response is presented.
REQ-012 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-013 SHALL have port rsp_rdata  output  32  read data.
REQ-014 SHALL have port rsp_err  output  1  access fault.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 SHALL capture we, addr, wdata and be at acceptance; later changes to the req_* inputs SHALL NOT affect the access.
REQ-018 SHALL flag an error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; an erroring access SHALL NOT modify storage and SHALL return rdata=0.
REQ-019 SHALL commit a non-error write on the acceptance edge, updating only the bytes whose be bit is 1; be=4'b0000 SHALL be a legal no-op write with err=0.
REQ-020 SHALL return the full addressed word on a read, ignoring be; a write response SHALL carry rdata=0.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until the edge where rsp_ready=1, then return to IDLE.
REQ-022 SHALL assert req_ready in the cycle after the response handshake; back-to-back throughput is one access per (latency+1) cycles.
REQ-023 SHALL return a read of an address written by the immediately preceding access with the new data.
REQ-024 SHALL ignore rsp_ready outside RESP and req_valid outside IDLE.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the wait counter at 0.
REQ-026 SHALL, when reset occurs in WAIT or RESP, discard the pending response; a write already committed SHALL remain committed.
REQ-027 SHALL NOT clear storage contents on reset.
REQ-028 SHALL NOT accept a request in a cycle where rst=1.

Configuration
REQ-029 SHALL, when RV523_BUS_WAIT_STATES_EN is defined, pass from IDLE to WAIT on acceptance, count WAIT_CYCLES cycles, then enter RESP; rsp_valid first rises WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-030 SHALL, when RV523_BUS_WAIT_STATES_EN is undefined, pass from IDLE directly to RESP; rsp_valid rises in the cycle after acceptance, and the WAIT state and its counter SHALL be absent.

Structure
REQ-031 SHALL place the FSM state enum, address and data width constants and the byte-enable width in the shared package rv523_bus_pkg.
REQ-032 SHALL place storage in sub-module rv523_bus_sram, with one write port carrying byte enables and one asynchronous read port.

Verification
REQ-033 Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rdata=0xDEADBEEF, err=0; with the macro defined and WAIT_CYCLES=2, rsp_valid rises 3 cycles after acceptance.
REQ-034 Write 0x000000AA to 0x10 with be=4'b0001, then read -> 0xDEADBEAA.
REQ-035 Read 0x02 (misaligned), then read 0x100 with DEPTH_WORDS=64 -> each response has err=1 and rdata=0; storage is unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_* -> response stays stable, req_ready stays 0, and the response completes on the first rsp_ready=1 edge.
REQ-037 Assert rst in WAIT after accepting a write of 0x12345678 to 0x20 -> no rsp_valid, IDLE the next cycle, and a read of 0x20 returns 0x12345678.
REQ-038 Macro undefined, 4 back-to-back reads with rsp_ready=1 -> each rsp_valid comes 1 cycle after acceptance, with a new acceptance every 2 cycles.

Source files
------------

// File: rtl/rv523_bus_pkg.sv
// Shared widths and FSM state type for the rv523 bus responder and its storage.
package rv523_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rv523_bus_sram.sv
// Word-organised storage: one byte-enabled synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module rv523_bus_sram
    import rv523_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rv523_bus_responder.sv
// Single-outstanding bus responder in front of a word SRAM; writes commit on the acceptance edge.
// Optional wait states between acceptance and response are enabled by RV523_BUS_WAIT_STATES_EN.
module rv523_bus_responder
    import rv523_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("rv523_bus_responder: WAIT_CYCLES must be in 1..15");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic              acc_err;
    logic [DATA_W-1:0] mem_rdata;
`ifdef RV523_BUS_WAIT_STATES_EN
    logic [WCNT_W-1:0] cnt_q, cnt_d;
`endif

    // Valid/ready: a request transfers on a rising edge with req_valid && req_ready
    // (never while rst is high); a response transfers on a rising edge with rsp_valid && rsp_ready.
    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready && !rst;
    assign acc_err   = (req_addr[1:0] != 2'b00) ||
                       (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));

    rv523_bus_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk     (clk),
        .we_i    (accept && req_we && !acc_err),
        .waddr_i (req_addr[AW+1:2]),
        .wdata_i (req_wdata),
        .be_i    (req_be),
        .raddr_i (req_addr[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef RV523_BUS_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Read data is sampled at acceptance so the response never depends on later inputs.
                    rdata_d = (req_we || acc_err) ? '0 : mem_rdata;
                    err_d   = acc_err;
`ifdef RV523_BUS_WAIT_STATES_EN
                    state_d = ST_WAIT;
                    cnt_d   = '0;
`else
                    state_d = ST_RESP;
`endif
                end
            end
            ST_WAIT: begin
`ifdef RV523_BUS_WAIT_STATES_EN
                if (cnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef RV523_BUS_WAIT_STATES_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef RV523_BUS_WAIT_STATES_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Response fields read as zero whenever no response is being presented.
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule
